// File: rtl/hash160_pkg.sv
// hash160_pkg
// Shared definitions for the Hash160 sequencer: the controller state enum,
// the fixed datapath widths and the constant tail of the RIPEMD-160 block.
// No ports; imported by the interface, the message buffer and the top.

package hash160_pkg;

    localparam int IN_W      = 8;
    localparam int OUT_W     = 16;
    localparam int BLK_BYTES = 64;
    localparam int OUT_WORDS = 10;
    localparam int BLK_W     = IN_W * BLK_BYTES;

    // Padding that follows a 256-bit SHA digest to fill one RIPEMD-160 block:
    // the 0x80 marker, zero fill, then the 64-bit little-endian length (256).
    localparam logic [255:0] RMD_PAD_TAIL = {8'h80, 184'h0, 64'h0001_0000_0000_0000};

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SHA_RUN,
        RMD_RUN,
        OUT
    } state_t;

endpackage

// File: rtl/hash160_if.sv
// hash160_if
// Bundles the chip-pin signals and both hash-core handshakes.
// master: the controller view (drives results, starts and blocks).
// slave : the environment view (drives bytes, done pulses and digests).
//   i_valid/i_text        message byte stream in
//   o_answer/o_valid      digest words out
//   o_busy                controller not idle
//   sha_start/sha_block   SHA-256 core request
//   sha_done/sha_digest   SHA-256 core response
//   rmd_start/rmd_block   RIPEMD-160 core request
//   rmd_done/rmd_digest   RIPEMD-160 core response

import hash160_pkg::*;

interface hash160_if;
    logic              i_valid;
    logic [IN_W-1:0]   i_text;
    logic [OUT_W-1:0]  o_answer;
    logic              o_valid;
    logic              o_busy;
    logic              sha_start;
    logic [BLK_W-1:0]  sha_block;
    logic              sha_done;
    logic [255:0]      sha_digest;
    logic              rmd_start;
    logic [BLK_W-1:0]  rmd_block;
    logic              rmd_done;
    logic [159:0]      rmd_digest;

    modport master (
        input  i_valid, i_text, sha_done, sha_digest, rmd_done, rmd_digest,
        output o_answer, o_valid, o_busy, sha_start, sha_block, rmd_start, rmd_block
    );

    modport slave (
        output i_valid, i_text, sha_done, sha_digest, rmd_done, rmd_digest,
        input  o_answer, o_valid, o_busy, sha_start, sha_block, rmd_start, rmd_block
    );
endinterface

// File: rtl/hash160_msg_buf.sv
// hash160_msg_buf
// 64-byte message buffer. Each accepted byte is written at the current index
// (byte 0 lands in the most significant position) and the 6-bit count advances,
// wrapping to 0 after the 64th byte so the next message starts at byte 0.
//   clk, rst_n   clock and asynchronous active-low clear
//   wr_en        store wr_data at the current index
//   wr_data      message byte
//   block        buffered 512-bit block, byte 0 at [511:504]
//   count        number of bytes stored in the current message (mod 64)
//   full         set by the 64th byte, cleared by the next write

import hash160_pkg::*;

module hash160_msg_buf (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [IN_W-1:0]  wr_data,
    output logic [BLK_W-1:0] block,
    output logic [5:0]       count,
    output logic             full
);

    // Byte k sits at bit offset (63-k)*8; for a 6-bit k, 63-k is simply ~k.
    logic [8:0] wr_base;
    assign wr_base = {~count, 3'b000};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            block <= '0;
            count <= '0;
            full  <= 1'b0;
        end else if (wr_en) begin
            block[wr_base +: IN_W] <= wr_data;
            count                  <= count + 6'd1;
            full                   <= (count == 6'd63);
        end
    end

endmodule

// File: rtl/hash160_ctrl.sv
// hash160_ctrl
// Hash160 top-level sequencer: collects a 64-byte pre-padded block, runs the
// SHA-256 core on it, builds the padded RIPEMD-160 block from the SHA digest,
// runs the RIPEMD-160 core and streams the 160-bit result as ten 16-bit words.
//   clk, rst_n   clock and asynchronous active-low reset
//   bus          hash160_if master view (pins plus both core handshakes)

import hash160_pkg::*;

module hash160_ctrl (
    input  logic      clk,
    input  logic      rst_n,
    hash160_if.master bus
);

    state_t       state;
    state_t       state_next;
    logic [5:0]   byte_cnt;
    logic         buf_full;
    logic [BLK_W-1:0] buf_block;
    logic [159:0] rmd_dig;
    logic [3:0]   word_cnt;
    logic [7:0]   word_base;
    logic         accept_byte;
    logic         last_byte;

    assign accept_byte = bus.i_valid && ((state == IDLE) || (state == LOAD));
    assign last_byte   = accept_byte && (byte_cnt == 6'd63);

    // Word k of the digest starts at bit (9-k)*16.
    assign word_base = {4'(4'd9 - word_cnt), 4'b0000};

    hash160_msg_buf u_msg_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (accept_byte),
        .wr_data (bus.i_text),
        .block   (buf_block),
        .count   (byte_cnt),
        .full    (buf_full)
    );

    // The buffer registers feed the SHA core directly; they only change while
    // bytes are being accepted, so the block is stable throughout SHA_RUN.
    assign bus.sha_block = buf_block;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // A done pulse coinciding with the start pulse is ignored: the start
    // register is high exactly during the first cycle of its RUN state.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (accept_byte) state_next = LOAD;
            LOAD:    if (last_byte) state_next = SHA_RUN;
            SHA_RUN: if (bus.sha_done && !bus.sha_start) state_next = RMD_RUN;
            RMD_RUN: if (bus.rmd_done && !bus.rmd_start) state_next = OUT;
            OUT:     if (word_cnt == 4'(OUT_WORDS)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Registered outputs, digest latches and the output word counter. The SHA
    // digest is latched straight into the upper half of rmd_block.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.sha_start <= 1'b0;
            bus.rmd_start <= 1'b0;
            bus.rmd_block <= '0;
            bus.o_valid   <= 1'b0;
            bus.o_answer  <= '0;
            bus.o_busy    <= 1'b0;
            rmd_dig       <= '0;
            word_cnt      <= '0;
        end else begin
            bus.sha_start <= (state != SHA_RUN) && (state_next == SHA_RUN);
            bus.rmd_start <= (state == SHA_RUN) && (state_next == RMD_RUN);
            bus.o_busy    <= (state_next != IDLE);

            if ((state == SHA_RUN) && (state_next == RMD_RUN)) begin
                bus.rmd_block <= {bus.sha_digest, RMD_PAD_TAIL};
            end

            if ((state == RMD_RUN) && (state_next == OUT)) begin
                rmd_dig      <= bus.rmd_digest;
                bus.o_answer <= bus.rmd_digest[159 -: OUT_W];
                bus.o_valid  <= 1'b1;
                word_cnt     <= 4'd1;
            end else if (state == OUT) begin
                if (state_next == IDLE) begin
                    bus.o_answer <= '0;
                    bus.o_valid  <= 1'b0;
                    word_cnt     <= '0;
                end else begin
                    bus.o_answer <= rmd_dig[word_base +: OUT_W];
                    word_cnt     <= word_cnt + 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_hash160_ctrl.sv
// tb_hash160_ctrl
// Self-checking bench for hash160_ctrl. Behavioural stand-ins for the two
// hash cores answer 5 cycles after their start pulse; for the empty message
// they return the true SHA-256 / RIPEMD-160 values so the final words are the
// real Hash160 of the empty string.

import hash160_pkg::*;

module tb_hash160_ctrl;

    localparam logic [511:0] EMPTY_BLK = {8'h80, 504'h0};
    localparam logic [255:0] SHA_EMPTY =
        256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855;
    localparam logic [159:0] RMD_EMPTY =
        160'hb472a266_d0bd89c1_3706a413_2ccfb16f_7c3b9fcb;
    localparam logic [255:0] PAD_TB = {8'h80, 184'h0, 8'h00, 8'h01, 48'h0};

    logic clk;
    logic rst_n;
    logic stub_sha_done;
    logic spur_sha_done;
    logic [255:0] stub_sha_dig;
    logic stub_rmd_done;
    logic [159:0] stub_rmd_dig;

    int assertions = 0;
    int failures   = 0;

    logic [511:0] exp_sha_q[$];
    logic [511:0] exp_rmd_q[$];
    logic [15:0]  exp_word_q[$];

    hash160_if bus ();

    assign bus.sha_done   = stub_sha_done | spur_sha_done;
    assign bus.sha_digest = stub_sha_dig;
    assign bus.rmd_done   = stub_rmd_done;
    assign bus.rmd_digest = stub_rmd_dig;

    hash160_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] sha_model(input logic [511:0] b);
        if (b == EMPTY_BLK) return SHA_EMPTY;
        if (b[511:504] == 8'h00) return {32{8'h11}};
        return b[511:256] ^ b[255:0] ^ {8{32'h5a5a_0f0f}};
    endfunction

    function automatic logic [159:0] rmd_model(input logic [511:0] b);
        if (b == {SHA_EMPTY, PAD_TB}) return RMD_EMPTY;
        return b[511:352] ^ b[415:256] ^ 160'h0123_4567_89ab_cdef_fedc_ba98_7654_3210_a5a5_c3c3;
    endfunction

    task automatic checkOutput(input string tag, input logic [511:0] obs, input logic [511:0] exp);
        assertions++;
        if (obs !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // SHA-256 stand-in
    initial begin
        logic [511:0] blk;
        stub_sha_done = 1'b0;
        stub_sha_dig  = '0;
        forever begin
            @(negedge clk);
            if (bus.sha_start === 1'b1) begin
                blk = bus.sha_block;
                repeat (4) @(negedge clk);
                stub_sha_dig  = sha_model(blk);
                stub_sha_done = 1'b1;
                @(negedge clk);
                stub_sha_done = 1'b0;
            end
        end
    end

    // RIPEMD-160 stand-in
    initial begin
        logic [511:0] blk;
        stub_rmd_done = 1'b0;
        stub_rmd_dig  = '0;
        forever begin
            @(negedge clk);
            if (bus.rmd_start === 1'b1) begin
                blk = bus.rmd_block;
                repeat (4) @(negedge clk);
                stub_rmd_dig  = rmd_model(blk);
                stub_rmd_done = 1'b1;
                @(negedge clk);
                stub_rmd_done = 1'b0;
            end
        end
    end

    // Queue the expected results, then drive the 64 bytes. An optional
    // 3-cycle gap follows byte gap_after, with a stray sha_done inside it.
    task automatic applyStimulus(input logic [511:0] blk, input int gap_after, input bit spur);
        logic [255:0] d;
        logic [511:0] rb;
        logic [159:0] r;
        d  = sha_model(blk);
        rb = {d, PAD_TB};
        r  = rmd_model(rb);
        exp_sha_q.push_back(blk);
        exp_rmd_q.push_back(rb);
        for (int k = 0; k < 10; k++) exp_word_q.push_back(r[159 - 16*k -: 16]);
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            bus.i_valid = 1'b1;
            bus.i_text  = blk[511 - 8*i -: 8];
            if (i == gap_after) begin
                for (int g = 0; g < 3; g++) begin
                    @(negedge clk);
                    bus.i_valid   = 1'b0;
                    bus.i_text    = 8'hee;
                    spur_sha_done = spur && (g == 0);
                    if (g == 1) checkOutput("busy_in_gap", 512'(bus.o_busy), 512'd1);
                end
                spur_sha_done = 1'b0;
            end
        end
        @(negedge clk);
        bus.i_valid = 1'b0;
        checkOutput("sha_start_timing", 512'(bus.sha_start), 512'd1);
    endtask

    // Watch the DUT until the digest stream ends (or stop_words words were
    // seen), popping and comparing scoreboard entries as outputs appear.
    task automatic collectOutput(input logic [511:0] blk, input bit hold, input int stop_words);
        int n_sha = 0;
        int n_rmd = 0;
        int n_words = 0;
        bit done = 1'b0;
        for (int cyc = 0; cyc < 400 && !done; cyc++) begin
            if (cyc > 0) @(negedge clk);
            if (bus.sha_start === 1'b1) begin
                n_sha++;
                if (exp_sha_q.size() > 0) checkOutput("sha_block", bus.sha_block, exp_sha_q.pop_front());
                else checkOutput("sha_start_unexpected", 512'd1, 512'd0);
            end
            if (bus.rmd_start === 1'b1) begin
                n_rmd++;
                if (exp_rmd_q.size() > 0) checkOutput("rmd_block", bus.rmd_block, exp_rmd_q.pop_front());
                else checkOutput("rmd_start_unexpected", 512'd1, 512'd0);
            end
            if (bus.o_valid === 1'b1) begin
                n_words++;
                if (exp_word_q.size() > 0) checkOutput("o_answer", 512'(bus.o_answer), 512'(exp_word_q.pop_front()));
                else checkOutput("o_valid_extra", 512'd1, 512'd0);
                if (stop_words > 0 && n_words == stop_words) done = 1'b1;
            end else if (n_words > 0) begin
                done = 1'b1;
                checkOutput("o_answer_idle", 512'(bus.o_answer), 512'd0);
                checkOutput("o_busy_idle", 512'(bus.o_busy), 512'd0);
            end
            if (hold && !done) begin
                bus.i_valid = 1'b1;
                bus.i_text  = 8'($urandom_range(0, 255));
            end else begin
                bus.i_valid = 1'b0;
            end
        end
        bus.i_valid = 1'b0;
        if (!done) checkOutput("collect_timeout", 512'd0, 512'd1);
        checkOutput("sha_start_count", 512'(n_sha), 512'd1);
        checkOutput("rmd_start_count", 512'(n_rmd), 512'd1);
        if (stop_words == 0) checkOutput("o_valid_cycles", 512'(n_words), 512'd10);
        checkOutput("block_kept", bus.sha_block, blk);
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_o_valid"}, 512'(bus.o_valid), 512'd0);
        checkOutput({tag, "_o_answer"}, 512'(bus.o_answer), 512'd0);
        checkOutput({tag, "_o_busy"}, 512'(bus.o_busy), 512'd0);
        checkOutput({tag, "_sha_start"}, 512'(bus.sha_start), 512'd0);
        checkOutput({tag, "_rmd_start"}, 512'(bus.rmd_start), 512'd0);
        checkOutput({tag, "_sha_block"}, bus.sha_block, 512'd0);
        checkOutput({tag, "_rmd_block"}, bus.rmd_block, 512'd0);
    endtask

    initial begin
        logic [511:0] count_blk;
        logic [511:0] rnd_blk;

        bus.i_valid   = 1'b0;
        bus.i_text    = 8'h00;
        spur_sha_done = 1'b0;
        rst_n         = 1'b1;
        #2 rst_n      = 1'b0;
        repeat (3) @(negedge clk);
        checkResetState("reset");
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 64; i++) count_blk[511 - 8*i -: 8] = 8'(i);

        $display("[TB] empty message with golden core values");
        applyStimulus(EMPTY_BLK, -1, 1'b0);
        collectOutput(EMPTY_BLK, 1'b0, 0);

        $display("[TB] counting bytes, gap after byte 20, stray sha_done");
        applyStimulus(count_blk, 20, 1'b1);
        collectOutput(count_blk, 1'b0, 0);

        $display("[TB] random bytes, i_valid held high while busy");
        for (int i = 0; i < 64; i++) rnd_blk[511 - 8*i -: 8] = 8'($urandom_range(1, 255));
        applyStimulus(rnd_blk, -1, 1'b0);
        collectOutput(rnd_blk, 1'b1, 0);

        $display("[TB] reset during output after word 4");
        for (int i = 0; i < 64; i++) rnd_blk[511 - 8*i -: 8] = 8'($urandom_range(1, 255));
        applyStimulus(rnd_blk, -1, 1'b0);
        collectOutput(rnd_blk, 1'b0, 5);
        rst_n = 1'b0;
        #1;
        checkResetState("midout");
        exp_word_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] full message after reset");
        applyStimulus(count_blk, -1, 1'b0);
        collectOutput(count_blk, 1'b0, 0);

        repeat (2) @(negedge clk);
        checkOutput("leftover_words", 512'(exp_word_q.size()), 512'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
